// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register load-use countdown scoreboard driving stall and PC/IF-ID write enable.
// Optional HAZARD_PERF_EN builds a saturating stall-cycle counter on stall_cycles.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_memread,
    input  logic            id_regwrite,
    input  logic [AW-1:0]   id_wa,
    input  logic            flush,
    input  logic            freeze,
    output logic            PC_IFWrite,
    output logic            stall,
    output logic [NREG-1:0] pending,
    output logic [31:0]     stall_cycles
);
    logic [2**AW-1:0] w_pend_ext;
    logic             w_hazard;
    logic             w_arm;

    // Zero-extended view so register numbers >= NREG read as not pending.
    always_comb begin
        w_pend_ext             = '0;
        w_pend_ext[NREG-1:0]   = pending;
    end

    assign w_hazard   = id_valid && !flush &&
                        ((id_rs_used && w_pend_ext[id_rs]) || (id_rt_used && w_pend_ext[id_rt]));
    assign stall      = w_hazard && !freeze;
    assign PC_IFWrite = !w_hazard && !freeze;
    assign w_arm      = id_valid && !flush && !w_hazard && !freeze &&
                        id_memread && id_regwrite && (id_wa != '0);

    assign pending[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [3:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt <= '0;
            else if (!freeze)
                r_cnt <= (w_arm && id_wa == AW'(i)) ? 4'(LOAD_LAT) : (|r_cnt ? r_cnt - 4'd1 : r_cnt);
        end
        assign pending[i] = |r_cnt;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cycles <= '0;
        else if (stall && r_stall_cycles != '1)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end
    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use hazard unit for the pipelined CPU, sitting in ID beside the register file and driving the PC/IF-ID write enable and the ID/EX bubble control. It replaces the single-cycle compare against the EX destination with a per-register countdown scoreboard, so data-memory latency can be set without RTL changes. Loads issued from ID arm a counter for their destination. Any ID instruction that reads a register with a nonzero counter is held until the counter drains.

## Interface
- `NREG`, 32: number of architectural registers; register 0 is never pending.
- `AW`, 5: register address width, ≥ log2(NREG).
- `LOAD_LAT`, 1: bubbles needed between a load and a dependent consumer; legal range 1..15. A value of 1 gives classic MIPS one-bubble behaviour.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs`, `id_rt` input AW: source register numbers.
- `id_rs_used`, `id_rt_used` input 1: the corresponding source is actually read.
- `id_memread` input 1: the ID instruction is a load.
- `id_regwrite` input 1: the ID instruction writes a register.
- `id_wa` input AW: destination register of the ID instruction.
- `flush` input 1: branch/jump squash of the ID instruction this cycle.
- `freeze` input 1: global pipeline hold (data memory busy).
- `PC_IFWrite` output 1: PC and IF/ID write enable, active high.
- `stall` output 1: zero the ID/EX control fields (insert bubble).
- `pending` output NREG: bit r = cnt[r] ≠ 0.
- `stall_cycles` output 32: stall performance counter (see Configuration).

## Operation
- State: cnt[r], 4 bits, for r = 1..NREG-1. cnt[0] is constant 0.
- hazard = id_valid & !flush & ((id_rs_used & cnt[id_rs]≠0) | (id_rt_used & cnt[id_rt]≠0)). This is combinational.
- stall = hazard & !freeze.
- PC_IFWrite = !hazard & !freeze.
- issue = id_valid & !flush & !hazard & !freeze.
- arm = issue & id_memread & id_regwrite & (id_wa ≠ 0).
- Clock edge with freeze=1: all cnt hold.
- Clock edge with freeze=0, for each r:
  - if arm & id_wa==r: cnt[r] ← LOAD_LAT;
  - else if cnt[r]≠0: cnt[r] ← cnt[r]−1.
- Non-load writers (ALU results) never arm. They are covered by forwarding.
- Re-arm on the same register reloads LOAD_LAT; reload wins over decrement in the same cycle.
- A load whose destination is also one of its own sources is checked against the old counter first. It arms only when it issues.
- flush with a hazard present: stall=0, PC_IFWrite=1, nothing arms. The squashed instruction does not wait.
- Out-of-range register numbers (≥ NREG) read as not pending and never arm.

## Timing
- Reset (rst_n=0, asynchronous): all cnt=0, pending=0, stall_cycles=0. Outputs settle to stall=0 and PC_IFWrite=!freeze.
- stall, PC_IFWrite and hazard are same-cycle combinational from the ID inputs and registered cnt. There is no added latency.
- A load issued at edge t makes its destination pending from t to t+LOAD_LAT. A dependent in ID sees exactly LOAD_LAT stall cycles, absent freeze.
- freeze extends the pending window one cycle per frozen cycle. During freeze, stall=0 and PC_IFWrite=0.
- Reset asserted mid-countdown clears everything immediately. The first edge after release behaves as if nothing is pending.

## Configuration
- `HAZARD_PERF_EN` defined:
  - stall_cycles increments on every edge where stall=1;
  - it saturates at 32'hFFFF_FFFF;
  - it is cleared by rst_n.
- `HAZARD_PERF_EN` undefined: stall_cycles is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- LOAD_LAT=1: load to r8 issues, then a consumer reading r8 via rs sits in ID → exactly 1 cycle with stall=1 and PC_IFWrite=0, then issue. pending[8] is high for 1 cycle.
- LOAD_LAT=3: load to r5, then an independent instruction, then a consumer reading r5 via rt → 2 stall cycles (counter already at 2 when the consumer reaches ID).
- Load to r0, or an ALU write to r9 followed by a consumer of r0/r9 → stall never asserts and pending stays 0.
- LOAD_LAT=2: consumer of r4 stalled with cnt[4]=1, freeze held for 3 cycles → cnt[4] stays 1 and stall=0 while frozen. After freeze drops, 1 more stall cycle, then issue.
- Hazard on r6 with flush=1 in the same cycle → stall=0, PC_IFWrite=1. A squashed load to r7 does not set pending[7].
- With `HAZARD_PERF_EN`, run the LOAD_LAT=3 back-to-back dependent case (3 stalls), then pulse rst_n low mid-countdown → stall_cycles reads 3 before reset and 0 after, and all pending bits clear asynchronously.
